// File: rtl/pong_game_ctrl.sv
// Game-sequencing FSM for the pong design: freezes/releases the ball, keeps a BCD score,
// counts balls remaining and times the pauses between balls and after game-over.
module pong_game_ctrl #(
  parameter int unsigned BALLS      = 3,
  parameter int unsigned WAIT_TICKS = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] btn,
  input  logic       refr_tick,
  input  logic       hit,
  input  logic       miss,
  output logic       gra_still,
  output logic [1:0] game_state,
  output logic [7:0] score,
  output logic [1:0] balls,
  output logic       timer_up
);

  typedef enum logic [1:0] {
    StNewGame = 2'b00,
    StPlay    = 2'b01,
    StNewBall = 2'b10,
    StOver    = 2'b11
  } state_e;

  localparam logic [1:0] BallsInit = 2'(BALLS);
  localparam logic [7:0] TimerLoad = 8'(WAIT_TICKS - 1);

  state_e     state_q;
  logic [7:0] score_q;
  logic [7:0] score_inc;
  logic [1:0] balls_q;
  logic [7:0] timer_q;
  logic       timer_up_q;
  logic       gra_still_q;

  // BCD increment, saturating at 99
  always_comb begin
    score_inc = score_q;
    if (score_q != 8'h99) begin
      if (score_q[3:0] == 4'd9) begin
        score_inc[3:0] = 4'd0;
        score_inc[7:4] = score_q[7:4] + 4'd1;
      end else begin
        score_inc[3:0] = score_q[3:0] + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StNewGame;
      score_q     <= 8'h00;
      balls_q     <= BallsInit;
      timer_q     <= 8'd0;
      timer_up_q  <= 1'b1;
      gra_still_q <= 1'b1;
    end else begin
      // A tick at zero flags expiry, so the full pause spans WAIT_TICKS ticks after a load.
      if (refr_tick) begin
        if (timer_q == 8'd0) begin
          timer_up_q <= 1'b1;
        end else begin
          timer_q <= timer_q - 8'd1;
        end
      end

      unique case (state_q)
        StNewGame: begin
          balls_q <= BallsInit;
          if (|btn) begin
            state_q     <= StPlay;
            score_q     <= 8'h00;
            balls_q     <= BallsInit - 2'd1;
            gra_still_q <= 1'b0;
          end
        end
        StPlay: begin
          // Loads below override the tick update above: load wins.
          if (miss) begin
            state_q     <= (balls_q == 2'd0) ? StOver : StNewBall;
            timer_q     <= TimerLoad;
            timer_up_q  <= 1'b0;
            gra_still_q <= 1'b1;
          end else if (hit) begin
            score_q <= score_inc;
          end
        end
        StNewBall: begin
          if (timer_up_q && (|btn)) begin
            state_q     <= StPlay;
            balls_q     <= balls_q - 2'd1;
            gra_still_q <= 1'b0;
          end
        end
        StOver: begin
          if (timer_up_q) begin
            state_q <= StNewGame;
            balls_q <= BallsInit;
          end
        end
        default: state_q <= StNewGame;
      endcase
    end
  end

  assign gra_still  = gra_still_q;
  assign game_state = state_q;
  assign score      = score_q;
  assign balls      = balls_q;
  assign timer_up   = timer_up_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl with hand-computed expectations (BALLS=3, WAIT_TICKS=120).
module tb_pong_game_ctrl;

  logic       clk;
  logic       reset;
  logic [1:0] btn;
  logic       refr_tick;
  logic       hit;
  logic       miss;
  logic       gra_still;
  logic [1:0] game_state;
  logic [7:0] score;
  logic [1:0] balls;
  logic       timer_up;

  int n_total;
  int n_bad;

  pong_game_ctrl #(
    .BALLS      (3),
    .WAIT_TICKS (120)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn        (btn),
    .refr_tick  (refr_tick),
    .hit        (hit),
    .miss       (miss),
    .gra_still  (gra_still),
    .game_state (game_state),
    .score      (score),
    .balls      (balls),
    .timer_up   (timer_up)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; sample and drive 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    refr_tick = 1'b1;
    step();
    refr_tick = 1'b0;
    step();
  endtask

  task automatic pulse_hit(input int n);
    for (int i = 0; i < n; i++) begin
      hit = 1'b1;
      step();
      hit = 1'b0;
    end
  endtask

  task automatic press();
    btn = 2'b01;
    step();
    btn = 2'b00;
  endtask

  initial begin
    n_total   = 0;
    n_bad     = 0;
    reset     = 1'b0;
    btn       = 2'b00;
    refr_tick = 1'b0;
    hit       = 1'b0;
    miss      = 1'b0;

    #12;
    check_eq("rst_state", game_state, 2'b00);
    check_eq("rst_score", score, 8'h00);
    check_eq("rst_balls", balls, 2'd3);
    check_eq("rst_timer_up", timer_up, 1'b1);
    check_eq("rst_still", gra_still, 1'b1);
    step();
    reset = 1'b1;
    step();
    check_eq("idle_state", game_state, 2'b00);

    // Start game
    btn = 2'b01;
    step();
    btn = 2'b00;
    check_eq("start_state", game_state, 2'b01);
    check_eq("start_still", gra_still, 1'b0);
    check_eq("start_score", score, 8'h00);
    check_eq("start_balls", balls, 2'd2);

    // BCD scoring and saturation
    pulse_hit(10);
    check_eq("score_10", score, 8'h10);
    pulse_hit(1);
    check_eq("score_11", score, 8'h11);
    btn = 2'b11;
    step();
    btn = 2'b00;
    check_eq("btn_in_play", game_state, 2'b01);
    pulse_hit(88);
    check_eq("score_99", score, 8'h99);
    pulse_hit(1);
    check_eq("score_sat", score, 8'h99);

    // Miss with balls=2 -> NEWBALL countdown
    miss = 1'b1;
    step();
    miss = 1'b0;
    check_eq("nb_state", game_state, 2'b10);
    check_eq("nb_still", gra_still, 1'b1);
    check_eq("nb_timer_up", timer_up, 1'b0);
    btn = 2'b10;
    for (int i = 0; i < 119; i++) tick();
    check_eq("nb_early_btn", game_state, 2'b10);
    check_eq("nb_119_timer_up", timer_up, 1'b0);
    btn = 2'b00;
    refr_tick = 1'b1;
    step();
    refr_tick = 1'b0;
    check_eq("nb_120_timer_up", timer_up, 1'b1);
    step();
    check_eq("nb_wait_btn", game_state, 2'b10);
    press();
    check_eq("nb_resume", game_state, 2'b01);
    check_eq("nb_balls1", balls, 2'd1);
    check_eq("nb_resume_still", gra_still, 1'b0);

    // Second ball lost, then last ball
    miss = 1'b1;
    step();
    miss = 1'b0;
    for (int i = 0; i < 120; i++) tick();
    press();
    check_eq("play_balls0", balls, 2'd0);
    check_eq("play_state2", game_state, 2'b01);
    miss = 1'b1;
    step();
    miss = 1'b0;
    check_eq("over_state", game_state, 2'b11);
    check_eq("over_timer_up", timer_up, 1'b0);
    check_eq("over_still", gra_still, 1'b1);
    for (int i = 0; i < 119; i++) tick();
    check_eq("over_119", game_state, 2'b11);
    refr_tick = 1'b1;
    step();
    refr_tick = 1'b0;
    check_eq("over_120_timer_up", timer_up, 1'b1);
    check_eq("over_120_state", game_state, 2'b11);
    step();
    check_eq("over_to_new", game_state, 2'b00);
    check_eq("over_score_kept", score, 8'h99);
    check_eq("over_balls", balls, 2'd3);

    // hit/miss ignored in NEWGAME
    hit  = 1'b1;
    miss = 1'b1;
    step();
    hit  = 1'b0;
    miss = 1'b0;
    step();
    check_eq("ng_hitmiss_state", game_state, 2'b00);
    check_eq("ng_hitmiss_score", score, 8'h99);

    // New game, hit+miss together
    press();
    check_eq("g2_score", score, 8'h00);
    check_eq("g2_balls", balls, 2'd2);
    pulse_hit(3);
    check_eq("g2_score3", score, 8'h03);
    hit  = 1'b1;
    miss = 1'b1;
    step();
    hit  = 1'b0;
    miss = 1'b0;
    check_eq("hm_score", score, 8'h03);
    check_eq("hm_state", game_state, 2'b10);

    // Asynchronous reset mid-countdown
    for (int i = 0; i < 5; i++) tick();
    #2;
    reset = 1'b0;
    #1;
    check_eq("arst_state", game_state, 2'b00);
    check_eq("arst_score", score, 8'h00);
    check_eq("arst_balls", balls, 2'd3);
    check_eq("arst_timer_up", timer_up, 1'b1);
    check_eq("arst_still", gra_still, 1'b1);
    step();
    reset = 1'b1;
    step();
    press();
    check_eq("post_rst_play", game_state, 2'b01);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
